// File: rtl/mult_div_pkg.sv
// Shared types and op encodings for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSign,
    StZero
  } md_state_e;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_step.sv
// Single iteration of the multiply (shift-add) or restoring divide (shift-subtract) datapath.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               op_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: upper half accumulates, lower half shifts the multiplier out.
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: upper half is the partial remainder, lower half shifts dividend in / quotient out.
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (op_i == MD_OP_MULT) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit; define MULT_DIV_SIGNED_EN for two's-complement operands,
// otherwise operands are unsigned.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef MULT_DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  md_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  assign a_neg = SignedEn && a_i[WIDTH-1];
  assign b_neg = SignedEn && b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  mult_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d   = op_i;
          opnd_d = b_mag;
          acc_d  = {{WIDTH{1'b0}}, a_mag};
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          // Divide-by-zero spends one extra cycle in ZERO for a fixed two-edge latency.
          if (op_i == MD_OP_DIV && b_i == '0) begin
            state_d = StZero;
            cnt_d   = CntW'(1);
          end else begin
            state_d = StCalc;
            cnt_d   = CntW'(WIDTH);
          end
        end
      end
      StCalc: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StSign;
        end
      end
      StSign: begin
        if (op_q == MD_OP_MULT) begin
          {hi_d, lo_d} = prod;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StZero: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          done_d  = 1'b1;
          dz_d    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= MD_OP_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit; expectations follow MULT_DIV_SIGNED_EN when it is defined.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, dz;

  logic         start8 = 1'b0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic [7:0]   hi8, lo8;
  logic         busy8, done8, dz8;

  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  exp_t         q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (dz)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock_i    (clk),
    .reset_i    (rst),
    .start_i    (start8),
    .op_i       (1'b0),
    .a_i        (a8),
    .b_i        (b8),
    .hi_o       (hi8),
    .lo_o       (lo8),
    .busy_o     (busy8),
    .done_o     (done8),
    .div_zero_o (dz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [2*W-1:0] ex, ey, r;
`ifdef MULT_DIV_SIGNED_EN
    ex = {{W{x[W-1]}}, x};
    ey = {{W{y[W-1]}}, y};
`else
    ex = {{W{1'b0}}, x};
    ey = {{W{1'b0}}, y};
`endif
    e.dz  = 1'b0;
    e.lat = W + 1;
    if (o == 1'b0) begin
      r    = ex * ey;
      e.hi = r[2*W-1:W];
      e.lo = r[W-1:0];
    end else if (y == '0) begin
      e.hi  = last_hi;
      e.lo  = last_lo;
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
      r    = ex / ey;
      e.lo = r[W-1:0];
      r    = ex % ey;
      e.hi = r[W-1:0];
    end
    return e;
  endfunction

  // Returns at a negedge where the DUT is idle.
  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check_eq("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    wait_idle();
    e = model(o, x, y);
    last_hi = e.hi;
    last_lo = e.lo;
    q.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      check_eq("done_pending", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
        check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
        check_eq("div_zero", {63'd0, dz}, {63'd0, e.dz});
        check_eq("latency", 64'(cyc - start_cyc), 64'(e.lat));
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_dz", {63'd0, dz}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'd100, 32'd7);
    issue(1'b1, 32'd5, 32'd0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'hFFFF_FFFF, 32'd2);
    issue(1'b0, 32'd0, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, $urandom, $urandom);
      issue(1'b1, $urandom, $urandom | 32'd1);
    end

    // A second start ten cycles into a multiply must be ignored.
    issue(1'b0, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd99;
    b     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check_eq("ignored_start_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of an operation aborts it.
    issue(1'b0, 32'd1000, 32'd3000);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    q.delete();
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("post_abort_busy", {63'd0, busy}, 64'd0);
    check_eq("post_abort_lo", {32'd0, lo}, 64'd0);
    issue(1'b1, 32'd1000, 32'd33);
    wait_idle();
    #1;
    check_eq("queue_drained", 64'(q.size()), 64'd0);

    // 8-bit instance: 0x0F * 0x0F.
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'h0F;
    b8     = 8'h0F;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("w8_latency", 64'(n), 64'd10);
    check_eq("w8_hi", {56'd0, hi8}, 64'h00);
    check_eq("w8_lo", {56'd0, lo8}, 64'hE1);
    check_eq("w8_busy", {63'd0, busy8}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multicycle multiply/divide unit that produces the HI/LO pair for MULT and DIV instructions in the multicycle CPU. The control unit pulses `start` with the operation and operands taken from A/B. The block computes over `WIDTH` iteration cycles and raises a one-cycle `done`. Results are then held for HI/LO write-back. It is parametrised in operand width and flags division by zero so the control unit can branch to the exception sequence.

## Interface
- `WIDTH`, default 32: operand width; `hi`/`lo` are each `WIDTH` bits; must be ≥ 4.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; returns every register to its reset value immediately.
- `start`  in  1  request, sampled only in IDLE; ignored otherwise.
- `op`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `a`  in  `WIDTH`  multiplicand / dividend; sampled with `start`.
- `b`  in  `WIDTH`  multiplier / divisor; sampled with `start`.
- `hi`  out  `WIDTH`  product upper half / remainder.
- `lo`  out  `WIDTH`  product lower half / quotient.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `div_zero`  out  1  high together with `done` when a divide had `b == 0`.

## Operation
- Reset values: `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`, `div_zero = 0`, state = IDLE, counter = 0.
- State machine:
  - IDLE: `start` loads the operand magnitudes and records the result signs.
    - Divide with `b == 0` goes to ZERO.
    - Otherwise goes to CALC with counter = `WIDTH`.
  - CALC: performs one step per cycle and decrements the counter; moves to SIGN when the counter reaches 1.
  - SIGN: applies signs, writes `hi`/`lo`, pulses `done`, returns to IDLE.
  - ZERO: pulses `done` and `div_zero`, returns to IDLE; `hi`/`lo` are unchanged.
- Multiply: shift-add of magnitudes into a 2·`WIDTH` accumulator. The result is negated if the operand signs differ. Upper half goes to `hi`, lower half to `lo`.
- Divide: restoring shift-subtract on magnitudes.
  - The quotient truncates toward zero and goes to `lo`.
  - The remainder takes the dividend's sign and goes to `hi`.
- Most-negative / −1 yields `lo` = most-negative and `hi` = 0. No overflow flag is produced.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- `done`, `div_zero` and `hi`/`lo` update only at the SIGN/ZERO exit edge. Outputs hold until the next completion.

## Timing
- Start edge = the edge that samples `start` in IDLE.
- Normal operation: `done` rises `WIDTH`+1 edges after the start edge, i.e. `WIDTH`+2 edges counting the start edge itself.
- Divide-by-zero: `done`/`div_zero` rise 2 edges after the start edge.
- `busy` rises at the start edge and falls on the edge that raises `done`.
- `start` during the `done` cycle is accepted, giving back-to-back operations.
- `reset` mid-operation aborts immediately. No `done` is produced, and all outputs take their reset values.

## Configuration
- `MULT_DIV_SIGNED_EN` defined: operands are two's complement; sign handling runs in SIGN (MULT/DIV semantics).
- `MULT_DIV_SIGNED_EN` undefined: operands are unsigned; SIGN only transfers results (MULTU/DIVU semantics). Latency is unchanged.

## Structure
- Package `mult_div_pkg` holds:
  - state enum (IDLE, CALC, SIGN, ZERO)
  - op encodings `MD_OP_MULT = 1'b0`, `MD_OP_DIV = 1'b1`
- One sub-module, `mult_div_step`: combinational single-iteration datapath (shift-add or shift-subtract selected by `op`). It is instantiated once inside the FSM/register top.

## Test plan
- Signed build, `WIDTH` = 32: mult 7 × −3 → `hi` = FFFFFFFF, `lo` = FFFFFFEB; `done` exactly 34 edges after start, `busy` low in the same cycle.
- Divide −7 / 2 → `lo` = FFFFFFFD, `hi` = FFFFFFFF; divide 100 / 7 → `lo` = 0000000E, `hi` = 00000002.
- Divide 5 / 0 after a prior result → `done` and `div_zero` 2 edges after start; `hi`/`lo` keep the prior values.
- Divide 80000000 / FFFFFFFF → `lo` = 80000000, `hi` = 00000000, `div_zero` = 0.
- Second `start` at cycle 10 of a multiply → ignored, first result correct. Then `reset` pulse mid-operation → all outputs 0 and no `done` until a new start.
- Unsigned build: mult FFFFFFFF × 2 → `hi` = 00000001, `lo` = FFFFFFFE. Also run with `WIDTH` = 8: mult 0x0F × 0x0F → `hi` = 0x00, `lo` = 0xE1 in 10 edges.
